// File: rtl/matmul_pkg.sv
// Shared types, widths and bus packing offsets for the 2x2 matrix-multiply sequencer.
package matmul_pkg;

    localparam int ELEM_W = 4;
    localparam int PROD_W = 8;
    localparam int ACC_W  = 9;
    localparam int DIM    = 2;

    // Bit offsets of each element in a_flat / b_flat (row-major, 4 bits each).
    localparam int AB_OFF_00 = 0;
    localparam int AB_OFF_01 = ELEM_W;
    localparam int AB_OFF_10 = 2 * ELEM_W;
    localparam int AB_OFF_11 = 3 * ELEM_W;

    // Bit offsets of each element in c_flat (row-major, 9 bits each).
    localparam int C_OFF_00 = 0;
    localparam int C_OFF_01 = ACC_W;
    localparam int C_OFF_10 = 2 * ACC_W;
    localparam int C_OFF_11 = 3 * ACC_W;

    localparam int AB_FLAT_W = DIM * DIM * ELEM_W;
    localparam int C_FLAT_W  = DIM * DIM * ACC_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL0 = 2'd1,
        ST_MUL1 = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/matmul_sequencer_if.sv
// Request/result bus of the matrix-multiply sequencer.
interface matmul_sequencer_if;
    import matmul_pkg::*;

    logic                 start;
    logic                 abort;
    logic [AB_FLAT_W-1:0] a_flat;
    logic [AB_FLAT_W-1:0] b_flat;
    logic                 busy;
    logic                 done;
    logic [C_FLAT_W-1:0]  c_flat;

    modport master (
        output start, abort, a_flat, b_flat,
        input  busy, done, c_flat
    );

    modport slave (
        input  start, abort, a_flat, b_flat,
        output busy, done, c_flat
    );

endinterface

// File: rtl/full_adder_8bit.sv
// 8-bit adder with carry in/out.
module full_adder_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] s,
    output logic       cout
);
    assign {cout, s} = {1'b0, a} + {1'b0, b} + {8'b0, cin};
endmodule

// File: rtl/matmul_mac.sv
// Shared multiply-accumulate datapath: sum = x*y + addend, carry-out lands in bit 8.
module matmul_mac
    import matmul_pkg::*;
(
    input  logic [ELEM_W-1:0] x,
    input  logic [ELEM_W-1:0] y,
    input  logic [PROD_W-1:0] addend,
    output logic [ACC_W-1:0]  sum
);
    logic [PROD_W-1:0] prod;
    logic [PROD_W-1:0] add_s;
    logic              add_c;

    multiplier_4bit u_mul (
        .x (x),
        .y (y),
        .p (prod)
    );

    full_adder_8bit u_add (
        .a    (prod),
        .b    (addend),
        .cin  (1'b0),
        .s    (add_s),
        .cout (add_c)
    );

    assign sum = {add_c, add_s};
endmodule

// File: rtl/multiplier_4bit.sv
// 4x4 unsigned multiplier, full 8-bit product.
module multiplier_4bit (
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic [7:0] p
);
    assign p = {4'b0, x} * {4'b0, y};
endmodule

// File: rtl/matmul_sequencer.sv
// 2x2 matrix product sequenced over one shared MAC, two edges per output element.
module matmul_sequencer
    import matmul_pkg::*;
#(
    parameter bit CLR_ON_START = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    matmul_sequencer_if.slave  bus
);
    state_e                          state;
    logic [DIM*DIM-1:0][ELEM_W-1:0]  a_reg;
    logic [DIM*DIM-1:0][ELEM_W-1:0]  b_reg;
    logic [DIM*DIM-1:0][ACC_W-1:0]   c_reg;
    logic [ACC_W-1:0]                acc;
    logic [1:0]                      idx;   // {i, j}, advances 00,01,10,11

    logic                            k;     // inner-product term: 0 in MUL0, 1 in MUL1
    logic [1:0]                      a_sel;
    logic [1:0]                      b_sel;
    logic [ELEM_W-1:0]               mac_x;
    logic [ELEM_W-1:0]               mac_y;
    logic [PROD_W-1:0]               mac_addend;
    logic [ACC_W-1:0]                mac_sum;

    // Select A[i][k], B[k][j]; first term adds zero, second adds the held partial.
    always_comb begin
        k          = (state == ST_MUL1);
        a_sel      = {idx[1], k};
        b_sel      = {k, idx[0]};
        mac_x      = a_reg[a_sel];
        mac_y      = b_reg[b_sel];
        mac_addend = k ? acc[PROD_W-1:0] : '0;
    end

    matmul_mac u_mac (
        .x      (mac_x),
        .y      (mac_y),
        .addend (mac_addend),
        .sum    (mac_sum)
    );

    // Sequencer: latch operands on start, alternate MUL0/MUL1 per element, pulse DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            a_reg <= '0;
            b_reg <= '0;
            c_reg <= '0;
            acc   <= '0;
            idx   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        a_reg <= bus.a_flat;
                        b_reg <= bus.b_flat;
                        idx   <= '0;
                        state <= ST_MUL0;
                        if (CLR_ON_START) c_reg <= '0;
                    end
                end
                ST_MUL0: begin
                    if (bus.abort) begin
                        state <= ST_IDLE;
                    end else begin
                        acc   <= mac_sum;
                        state <= ST_MUL1;
                    end
                end
                ST_MUL1: begin
                    if (bus.abort) begin
                        state <= ST_IDLE;
                    end else begin
                        c_reg[idx] <= mac_sum;
                        idx        <= idx + 2'd1;
                        state      <= (idx == 2'b11) ? ST_DONE : ST_MUL0;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy   = (state == ST_MUL0) || (state == ST_MUL1);
    assign bus.done   = (state == ST_DONE);
    assign bus.c_flat = c_reg;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed self-checking bench for matmul_sequencer.
module tb_matmul_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    matmul_sequencer_if bus_if ();

    matmul_sequencer #(.CLR_ON_START(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [35:0] c;
        string       name;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept a product, check busy window, 8-edge latency, result and one-cycle done.
    task automatic run_product(input vec_t v);
        int  n;
        bit  overlap;
        bit  busy_ok;
        bus_if.a_flat = v.a;
        bus_if.b_flat = v.b;
        bus_if.start  = 1'b1;
        tick();
        bus_if.start  = 1'b0;
        bus_if.a_flat = ~v.a;
        bus_if.b_flat = 16'($urandom);
        check({v.name, "_accept"}, {34'b0, bus_if.busy, bus_if.done}, 36'b10);
        check({v.name, "_clr"}, bus_if.c_flat, 36'b0);
        n = 0; overlap = 0; busy_ok = 1;
        do begin
            tick();
            n++;
            if (bus_if.busy && bus_if.done) overlap = 1;
            if (!bus_if.done && !bus_if.busy) busy_ok = 0;
        end while (!bus_if.done && n < 20);
        check({v.name, "_latency"}, 36'(n), 36'd8);
        check({v.name, "_busy_window"}, {34'b0, overlap, busy_ok}, 36'b01);
        check({v.name, "_c"}, bus_if.c_flat, v.c);
        tick();
        check({v.name, "_done_pulse"}, {34'b0, bus_if.busy, bus_if.done}, 36'b00);
    endtask

    initial begin
        int e, cnt, at;
        bit seen;

        vecs[0] = '{16'h4321, 16'h8765, {9'd50, 9'd43, 9'd22, 9'd19}, "basic"};
        vecs[1] = '{16'hFFFF, 16'hFFFF, {9'h1C2, 9'h1C2, 9'h1C2, 9'h1C2}, "all15"};
        vecs[2] = '{16'h9057, 16'hD62B, {9'd117, 9'd54, 9'd79, 9'd107}, "mixed"};
        vecs[3] = '{16'h1001, 16'hF039, {9'd15, 9'd0, 9'd3, 9'd9}, "identity"};

        rst_n = 1'b0;
        bus_if.start  = 1'b0;
        bus_if.abort  = 1'b0;
        bus_if.a_flat = '0;
        bus_if.b_flat = '0;
        #12;
        check("reset_outputs", {bus_if.busy, bus_if.done, bus_if.c_flat[33:0]}, 36'b0);
        check("reset_c", bus_if.c_flat, 36'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table: first start right after reset release must be accepted.
        for (int v = 0; v < 4; v++) run_product(vecs[v]);

        // Back-to-back start in the cycle after done: done rises 9 edges later.
        bus_if.a_flat = vecs[0].a;
        bus_if.b_flat = vecs[0].b;
        bus_if.start  = 1'b1;
        e = 0;
        do begin
            tick();
            bus_if.start = 1'b0;
            e++;
        end while (!bus_if.done && e < 20);
        check("b2b_latency", 36'(e), 36'd9);
        check("b2b_c", bus_if.c_flat, vecs[0].c);
        tick();

        // Abort together with start in IDLE blocks the start.
        bus_if.start = 1'b1;
        bus_if.abort = 1'b1;
        tick();
        bus_if.start = 1'b0;
        bus_if.abort = 1'b0;
        check("idle_abort_blocks", {34'b0, bus_if.busy, bus_if.done}, 36'b00);
        check("idle_abort_c_hold", bus_if.c_flat, vecs[0].c);

        // Second start mid-operation with zeroed A is ignored.
        bus_if.a_flat = vecs[0].a;
        bus_if.b_flat = vecs[0].b;
        bus_if.start  = 1'b1;
        tick();
        bus_if.start = 1'b0;
        tick();
        tick();
        bus_if.a_flat = '0;
        bus_if.start  = 1'b1;
        tick();
        bus_if.start = 1'b0;
        e = 3; cnt = 0; at = 0;
        for (int t = 0; t < 12; t++) begin
            tick();
            e++;
            if (bus_if.done) begin
                cnt++;
                at = e;
            end
        end
        check("ignore_start_done_count", 36'(cnt), 36'd1);
        check("ignore_start_done_edge", 36'(at), 36'd8);
        check("ignore_start_c", bus_if.c_flat, vecs[0].c);
        check("ignore_start_idle", {35'b0, bus_if.busy}, 36'b0);

        // Abort in MUL1 of (1,0): edge N+6.
        bus_if.a_flat = vecs[0].a;
        bus_if.b_flat = vecs[0].b;
        bus_if.start  = 1'b1;
        tick();
        bus_if.start = 1'b0;
        for (int t = 0; t < 5; t++) tick();
        bus_if.abort = 1'b1;
        tick();
        bus_if.abort = 1'b0;
        check("abort_idle", {34'b0, bus_if.busy, bus_if.done}, 36'b00);
        check("abort_partial_c", bus_if.c_flat, {9'd0, 9'd0, 9'd22, 9'd19});
        seen = 0;
        for (int t = 0; t < 10; t++) begin
            tick();
            if (bus_if.done || bus_if.busy) seen = 1;
        end
        check("abort_no_done", {35'b0, seen}, 36'b0);
        check("abort_c_hold", bus_if.c_flat, {9'd0, 9'd0, 9'd22, 9'd19});

        // Asynchronous reset mid-operation, then a clean run.
        bus_if.a_flat = vecs[2].a;
        bus_if.b_flat = vecs[2].b;
        bus_if.start  = 1'b1;
        tick();
        bus_if.start = 1'b0;
        for (int t = 0; t < 5; t++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_ctrl", {34'b0, bus_if.busy, bus_if.done}, 36'b00);
        check("async_reset_c", bus_if.c_flat, 36'b0);
        @(negedge clk);
        rst_n = 1'b1;
        run_product(vecs[1]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog.
    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
